i2_frame_loader: RTL and testbench

- Upstream capture stage for the i2 group-select decision logic.
- Takes the decision operand (V30/V62/V94/V126/V144/V176/V188 groups plus V193/V201 selects, 201 bits, zero-padded to 224) as a stream of W-bit words over a valid/ready handshake.
- Assembles the words into one parallel frame, holds the frame stable for the combinational decision logic, and releases it on acknowledge.
- Also produces per-word nonzero flags, so the downstream OR-reduction can use pre-reduced terms.

---
 rtl/i2_frame_loader_if.sv | 33 +++
 rtl/i2_frame_loader.sv | 98 +++++++++
 tb/tb_i2_frame_loader.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/i2_frame_loader_if.sv
// Stream-in / frame-out bus of the i2 frame loader.
// The slave modport is the loader side. The master modport is the producer/consumer side.
interface i2_frame_loader_if #(
    parameter int W      = 32,
    parameter int NWORDS = 7,
    parameter int CNTW   = 16
) ();
    localparam int FB = W * NWORDS;

    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic              in_last;
    logic              frame_valid;
    logic              frame_ready;
    logic [FB-1:0]     frame_data;
    logic [NWORDS-1:0] word_nz;
    logic              frame_err;
    logic [CNTW-1:0]   frame_count;
    logic [7:0]        err_count;

    modport slave (
        input  in_valid, in_data, in_last, frame_ready,
        output in_ready, frame_valid, frame_data, word_nz, frame_err,
               frame_count, err_count
    );

    modport master (
        output in_valid, in_data, in_last, frame_ready,
        input  in_ready, frame_valid, frame_data, word_nz, frame_err,
               frame_count, err_count
    );
endinterface

// File: rtl/i2_frame_loader.sv
// Assembles W-bit stream words into one held parallel operand frame for the i2 group-select logic.
// It also provides per-word nonzero flags and counts of delivered frames and error frames.
module i2_frame_loader #(
    parameter int W      = 32,
    parameter int NWORDS = 7,
    parameter int CNTW   = 16
) (
    input  logic               clk,
    input  logic               rst,
    i2_frame_loader_if.slave   bus
);
    localparam int FB = W * NWORDS;
    localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) + 1 : 1;

    typedef enum logic [1:0] {FILL, DRAIN, HOLD} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FB-1:0]     frame_q, frame_d;
    logic [NWORDS-1:0] nz_q, nz_d;
    logic              err_q, err_d;
    logic [CNTW-1:0]   fcnt_q, fcnt_d;
    logic [7:0]        ecnt_q, ecnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            frame_q <= '0;
            nz_q    <= '0;
            err_q   <= 1'b0;
            fcnt_q  <= '0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            nz_q    <= nz_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
            ecnt_q  <= ecnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        nz_d    = nz_q;
        err_d   = err_q;
        fcnt_d  = fcnt_q;
        ecnt_d  = ecnt_q;
        case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    frame_d[cnt_q*W +: W] = bus.in_data;
                    nz_d[cnt_q]           = |bus.in_data;
                    cnt_d                 = cnt_q + CW'(1);
                    if (bus.in_last) begin
                        state_d = HOLD;
                        err_d   = (cnt_q != CW'(NWORDS - 1));
                    end else if (cnt_q == CW'(NWORDS - 1)) begin
                        state_d = DRAIN;
                        err_d   = 1'b1;
                    end
                end
            end
            // Overlong frame: swallow beats until in_last, keeping the first NWORDS words.
            DRAIN: begin
                if (bus.in_valid && bus.in_last) begin
                    state_d = HOLD;
                    err_d   = 1'b1;
                end
            end
            HOLD: begin
                if (bus.frame_ready) begin
                    fcnt_d  = fcnt_q + CNTW'(1);
                    if (err_q && ecnt_q != 8'hFF)
                        ecnt_d = ecnt_q + 8'd1;
                    frame_d = '0;
                    nz_d    = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    assign bus.in_ready    = (state_q != HOLD);
    assign bus.frame_valid = (state_q == HOLD);
    assign bus.frame_data  = frame_q;
    assign bus.word_nz     = nz_q;
    assign bus.frame_err   = err_q;
    assign bus.frame_count = fcnt_q;
    assign bus.err_count   = ecnt_q;
endmodule

// File: tb/tb_i2_frame_loader.sv
// Directed bench for i2_frame_loader.
// It covers good, short, long and stalled frames, an async reset mid-frame, and err_count saturation.
module tb_i2_frame_loader;
    localparam int W  = 32;
    localparam int N  = 7;
    localparam int C  = 16;
    localparam int FB = W * N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2_frame_loader_if #(.W(W), .NWORDS(N), .CNTW(C)) bus ();
    i2_frame_loader #(.W(W), .NWORDS(N), .CNTW(C)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        logic acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!acc) chk("beat_timeout", 0, 1);
    endtask

    task automatic ack(input logic [C-1:0] fc, input logic [7:0] ec);
        bus.frame_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_ready = 1'b0;
        chk("ack_fvalid", bus.frame_valid, 0);
        chk("ack_iready", bus.in_ready, 1);
        chk("ack_fcount", bus.frame_count, fc);
        chk("ack_ecount", bus.err_count, ec);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_fvalid", bus.frame_valid, 0);
        chk("rst_fdata", bus.frame_data, 0);
        chk("rst_nz", bus.word_nz, 0);
        chk("rst_err", bus.frame_err, 0);
        chk("rst_fcount", bus.frame_count, 0);
        chk("rst_ecount", bus.err_count, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_iready", bus.in_ready, 1);
    endtask

    logic [FB-1:0] exp;

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_last     = 1'b0;
        bus.frame_ready = 1'b0;
        @(posedge clk);
        #2;
        do_reset();

        // good 7-word frame, word k = k
        exp = '0;
        for (int k = 0; k < N; k++) begin
            chk("t1_fvalid_pre", bus.frame_valid, 0);
            beat(32'(k), k == N - 1);
            exp[k*W +: W] = 32'(k);
        end
        chk("t1_fvalid", bus.frame_valid, 1);
        chk("t1_iready", bus.in_ready, 0);
        chk("t1_fdata", bus.frame_data, exp);
        chk("t1_nz", bus.word_nz, 7'b1111110);
        chk("t1_err", bus.frame_err, 0);
        ack(1, 0);
        chk("t1_cleared", bus.frame_data, 0);

        // short frame of 3 all-ones words
        for (int k = 0; k < 3; k++) beat(32'hFFFF_FFFF, k == 2);
        exp = '0;
        exp[95:0] = '1;
        chk("t2_fvalid", bus.frame_valid, 1);
        chk("t2_fdata", bus.frame_data, exp);
        chk("t2_nz", bus.word_nz, 7'b0000111);
        chk("t2_err", bus.frame_err, 1);
        ack(2, 1);

        // long frame of 10 beats
        exp = '0;
        for (int k = 0; k < 10; k++) begin
            chk("t3_iready", bus.in_ready, 1);
            chk("t3_fvalid_pre", bus.frame_valid, 0);
            beat(32'hA5A5_A5A5, k == 9);
            if (k < N) exp[k*W +: W] = 32'hA5A5_A5A5;
        end
        chk("t3_fvalid", bus.frame_valid, 1);
        chk("t3_fdata", bus.frame_data, exp);
        chk("t3_nz", bus.word_nz, 7'b1111111);
        chk("t3_err", bus.frame_err, 1);
        ack(3, 2);

        // held frame with in_valid asserted and no ack for 20 cycles
        exp = '0;
        for (int k = 0; k < N; k++) begin
            beat(32'h1000 + 32'(k), k == N - 1);
            exp[k*W +: W] = 32'h1000 + 32'(k);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("t4_iready", bus.in_ready, 0);
            chk("t4_fvalid", bus.frame_valid, 1);
        end
        chk("t4_fdata", bus.frame_data, exp);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        ack(4, 2);
        exp = '0;
        for (int k = 0; k < N; k++) begin
            beat(32'h2000 + 32'(k), k == N - 1);
            exp[k*W +: W] = 32'h2000 + 32'(k);
        end
        chk("t4_next_fdata", bus.frame_data, exp);
        chk("t4_next_err", bus.frame_err, 0);
        ack(5, 2);

        // async reset after 4 beats of a frame
        for (int k = 0; k < 4; k++) beat(32'h3000 + 32'(k), 1'b0);
        #2;
        do_reset();
        exp = '0;
        for (int k = 0; k < N; k++) begin
            beat(32'h4000 + 32'(k), k == N - 1);
            exp[k*W +: W] = 32'h4000 + 32'(k);
        end
        chk("t5_fdata", bus.frame_data, exp);
        chk("t5_err", bus.frame_err, 0);
        ack(1, 0);

        // 256 one-word short frames saturate err_count
        #2;
        do_reset();
        for (int f = 0; f < 256; f++) begin
            beat(32'h1, 1'b1);
            if (f == 0) begin
                chk("t6_nz", bus.word_nz, 7'b0000001);
                chk("t6_err", bus.frame_err, 1);
            end
            ack(16'(f + 1), (f < 255) ? 8'(f + 1) : 8'd255);
        end
        chk("t6_fcount", bus.frame_count, 256);
        chk("t6_ecount", bus.err_count, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
